// File: rtl/alu_shift_sched.sv
// alu_shift_sched: round-robin issue scheduler in front of a shared alu_shift
// datapath. One request is granted per cycle into the result stage (S1); the
// op then moves into the flags stage (S2). The shifter registers its flags,
// so they appear one cycle after the result. Writeback stall holds S1 and
// inserts a bubble into S2. A per-thread exception flush kills matching ops
// in either stage.
//
// Handshake: a requester raises req_valid[i] with its op/tag/thread and keeps
// all of them stable until the cycle in which req_gnt[i] is high. That cycle
// is the transfer. req_gnt is combinational and depends on this cycle's
// inputs, so the requester drops or replaces its request after that edge.
module alu_shift_sched #(
    parameter int NREQ            = 3,
    parameter int OPERATION_WIDTH = 13,
    parameter int TAG_WIDTH       = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            except,
    input  logic                            except_thread,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_thread,
    input  logic [NREQ*OPERATION_WIDTH-1:0] req_op,
    input  logic [NREQ*TAG_WIDTH-1:0]       req_tag,
    output logic [NREQ-1:0]                 req_gnt,
    input  logic                            wb_stall,
    output logic                            sh_dataEn,
    output logic [1:0]                      sh_sel,
    output logic [OPERATION_WIDTH-1:0]      sh_operation,
    output logic                            res_valid,
    output logic [TAG_WIDTH-1:0]            res_tag,
    output logic                            res_thread,
    output logic                            flags_valid,
    output logic [TAG_WIDTH-1:0]            flags_tag,
    output logic [1:0]                      inflight
);

    localparam int         OW    = OPERATION_WIDTH;
    localparam logic [2:0] NREQ3 = 3'(NREQ);
    localparam logic [1:0] LAST  = 2'(NREQ - 1);

    // Round-robin pointer: the port searched first in the next arbitration.
    logic [1:0] rr_ptr;

    // Result stage (S1): the op whose operands are live at the shifter.
    logic                 s1_valid;
    logic [OW-1:0]        s1_op;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic                 s1_thread;
    logic [1:0]           s1_sel;

    // Flags stage (S2): the op whose registered flags are on the shifter.
    logic                 s2_valid;
    logic [TAG_WIDTH-1:0] s2_tag;
    logic                 s2_thread;

    // Per-port unpacked views and eligibility.
    logic [OW-1:0]        op_arr  [NREQ];
    logic [TAG_WIDTH-1:0] tag_arr [NREQ];
    logic [NREQ-1:0]      elig;

    // Arbitration results.
    logic                 grant_ok;
    logic                 gnt_any;
    logic [1:0]           gnt_idx;
    logic [2:0]           idx;
    logic [7:0]           elig_pad;
    logic [OW-1:0]        gnt_op;
    logic [TAG_WIDTH-1:0] gnt_tag;
    logic                 gnt_thread;
    logic [1:0]           rr_next;

    // Pipeline control.
    logic s1_kill;
    logic s2_kill;
    logic s1_adv;
    logic s1_load;

    // A port is eligible only for shift-class opcodes (5..7) with bit 11 clear,
    // and not while its thread is being flushed.
    for (genvar g = 0; g < NREQ; g++) begin : g_port
        logic [5:0] opc;
        assign op_arr[g]  = req_op[g*OW +: OW];
        assign tag_arr[g] = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
        assign opc        = op_arr[g][7:2];
        assign elig[g]    = req_valid[g]
                          && (opc == 6'd5 || opc == 6'd6 || opc == 6'd7)
                          && !op_arr[g][11]
                          && !(except && (req_thread[g] == except_thread));
    end

    // Flush matches are evaluated against the current stage contents; the
    // kill takes effect at the next edge and wins over stall and advance.
    assign s1_kill = except && s1_valid && (s1_thread == except_thread);
    assign s2_kill = except && s2_valid && (s2_thread == except_thread);
    assign s1_adv  = s1_valid && !wb_stall;

    // S1 can accept a new op when it is empty or draining into S2. A stalled,
    // occupied S1 blocks the grant. Nothing is granted while in reset.
    assign grant_ok = rst && (!s1_valid || !wb_stall);

    // S1 is rewritten (with a grant or a bubble) whenever it is empty, moving
    // on, or being flushed; otherwise a stall holds it.
    assign s1_load = !s1_valid || !wb_stall || s1_kill;

    // Round-robin search: first eligible port upward from rr_ptr, modulo NREQ.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = 2'd0;
        idx      = 3'd0;
        elig_pad = 8'(elig);
        if (grant_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = {1'b0, rr_ptr} + 3'(k);
                if (idx >= NREQ3) begin
                    idx = idx - NREQ3;
                end
                if (!gnt_any && elig_pad[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx[1:0];
                end
            end
        end
    end

    // One-hot grant decode and payload selection of the winning port.
    always_comb begin
        req_gnt    = '0;
        gnt_op     = '0;
        gnt_tag    = '0;
        gnt_thread = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && (gnt_idx == 2'(i))) begin
                req_gnt[i] = 1'b1;
                gnt_op     = op_arr[i];
                gnt_tag    = tag_arr[i];
                gnt_thread = req_thread[i];
            end
        end
    end

    assign rr_next = (gnt_idx == LAST) ? 2'd0 : gnt_idx + 2'd1;

    // Round-robin pointer moves past the winner only when a grant happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 2'd0;
        end else if (gnt_any) begin
            rr_ptr <= rr_next;
        end
    end

    // S1 register: load the grant (or a bubble) unless a stall holds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_tag    <= '0;
            s1_thread <= 1'b0;
            s1_sel    <= 2'd0;
        end else if (s1_load) begin
            s1_valid <= gnt_any;
            if (gnt_any) begin
                s1_op     <= gnt_op;
                s1_tag    <= gnt_tag;
                s1_thread <= gnt_thread;
                s1_sel    <= gnt_idx;
            end
        end
    end

    // S2 register: receives a surviving S1 op when S1 advances, else a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_tag    <= '0;
            s2_thread <= 1'b0;
        end else begin
            s2_valid <= s1_adv && !s1_kill;
            if (s1_adv) begin
                s2_tag    <= s1_tag;
                s2_thread <= s1_thread;
            end
        end
    end

    assign sh_dataEn    = s1_valid;
    assign res_valid    = s1_valid;
    assign sh_sel       = s1_sel;
    assign sh_operation = s1_op;
    assign res_tag      = s1_tag;
    assign res_thread   = s1_thread;

    // Flags of an op whose thread is being flushed are suppressed at once.
    assign flags_valid  = s2_valid && !s2_kill;
    assign flags_tag    = s2_tag;

    assign inflight     = {1'b0, s1_valid} + {1'b0, s2_valid};

endmodule

// File: tb/tb_alu_shift_sched.sv
// tb_alu_shift_sched: directed vector table for arbitration, latency, stall
// and opcode filtering, plus hand-written flush and mid-operation reset runs.
module tb_alu_shift_sched;

    localparam int NREQ = 3;
    localparam int OW   = 13;
    localparam int TW   = 9;

    localparam logic [OW-1:0] OP4   = 13'h0010;
    localparam logic [OW-1:0] OP5   = 13'h0014;
    localparam logic [OW-1:0] OP6   = 13'h0018;
    localparam logic [OW-1:0] OP7   = 13'h001C;
    localparam logic [OW-1:0] OP8   = 13'h0020;
    localparam logic [OW-1:0] OPX11 = 13'h0814;

    logic                 clk;
    logic                 rst;
    logic                 except;
    logic                 except_thread;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_thread;
    logic [NREQ*OW-1:0]   req_op;
    logic [NREQ*TW-1:0]   req_tag;
    logic [NREQ-1:0]      req_gnt;
    logic                 wb_stall;
    logic                 sh_dataEn;
    logic [1:0]           sh_sel;
    logic [OW-1:0]        sh_operation;
    logic                 res_valid;
    logic [TW-1:0]        res_tag;
    logic                 res_thread;
    logic                 flags_valid;
    logic [TW-1:0]        flags_tag;
    logic [1:0]           inflight;

    int checks   = 0;
    int failures = 0;

    alu_shift_sched #(
        .NREQ(NREQ),
        .OPERATION_WIDTH(OW),
        .TAG_WIDTH(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .except(except),
        .except_thread(except_thread),
        .req_valid(req_valid),
        .req_thread(req_thread),
        .req_op(req_op),
        .req_tag(req_tag),
        .req_gnt(req_gnt),
        .wb_stall(wb_stall),
        .sh_dataEn(sh_dataEn),
        .sh_sel(sh_sel),
        .sh_operation(sh_operation),
        .res_valid(res_valid),
        .res_tag(res_tag),
        .res_thread(res_thread),
        .flags_valid(flags_valid),
        .flags_tag(flags_tag),
        .inflight(inflight)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    valid;
        logic [2:0]    thread;
        logic [OW-1:0] op0, op1, op2;
        logic [TW-1:0] tag0, tag1, tag2;
        logic          stall;
        logic [2:0]    e_gnt;
        logic          e_rv;
        logic [TW-1:0] e_rtag;
        logic          e_fv;
        logic [TW-1:0] e_ftag;
        logic [1:0]    e_inf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] thr,
                                input logic [OW-1:0] o0, input logic [OW-1:0] o1,
                                input logic [OW-1:0] o2, input logic [TW-1:0] t0,
                                input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                                input logic st, input logic [2:0] g, input logic rv,
                                input logic [TW-1:0] rt, input logic fv,
                                input logic [TW-1:0] ft, input logic [1:0] inf);
        vec_t r;
        r.valid = v;   r.thread = thr;
        r.op0 = o0;    r.op1 = o1;    r.op2 = o2;
        r.tag0 = t0;   r.tag1 = t1;   r.tag2 = t2;
        r.stall = st;  r.e_gnt = g;   r.e_rv = rv;  r.e_rtag = rt;
        r.e_fv = fv;   r.e_ftag = ft; r.e_inf = inf;
        return r;
    endfunction

    // Driver tasks
    task automatic drive(input logic [2:0] v, input logic [2:0] thr,
                         input logic [OW-1:0] o0, input logic [OW-1:0] o1,
                         input logic [OW-1:0] o2, input logic [TW-1:0] t0,
                         input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                         input logic st, input logic exc, input logic ethr);
        req_valid     = v;
        req_thread    = thr;
        req_op        = {o2, o1, o0};
        req_tag       = {t2, t1, t0};
        wb_stall      = st;
        except        = exc;
        except_thread = ethr;
    endtask

    task automatic idle();
        drive(3'b000, 3'b000, OP5, OP5, OP5, 9'h0, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard comparisons
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [2:0] g, input logic rv,
                             input logic [TW-1:0] rt, input logic fv,
                             input logic [TW-1:0] ft, input logic [1:0] inf);
        chk({nm, " gnt"}, 32'(req_gnt), 32'(g));
        chk({nm, " res_valid"}, 32'(res_valid), 32'(rv));
        chk({nm, " sh_dataEn"}, 32'(sh_dataEn), 32'(rv));
        if (rv) chk({nm, " res_tag"}, 32'(res_tag), 32'(rt));
        chk({nm, " flags_valid"}, 32'(flags_valid), 32'(fv));
        if (fv) chk({nm, " flags_tag"}, 32'(flags_tag), 32'(ft));
        chk({nm, " inflight"}, 32'(inflight), 32'(inf));
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " gnt"}, 32'(req_gnt), 32'h0);
        chk({nm, " res_valid"}, 32'(res_valid), 32'h0);
        chk({nm, " sh_dataEn"}, 32'(sh_dataEn), 32'h0);
        chk({nm, " flags_valid"}, 32'(flags_valid), 32'h0);
        chk({nm, " inflight"}, 32'(inflight), 32'h0);
        chk({nm, " sh_operation"}, 32'(sh_operation), 32'h0);
        chk({nm, " res_tag"}, 32'(res_tag), 32'h0);
        chk({nm, " flags_tag"}, 32'(flags_tag), 32'h0);
        chk({nm, " sh_sel"}, 32'(sh_sel), 32'h0);
        chk({nm, " res_thread"}, 32'(res_thread), 32'h0);
    endtask

    initial begin
        // Vector table: arbitration, stall, single-op latency, opcode filter.
        // Round robin across three held requests.
        tbl.push_back(mk(3'b111, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b0, 3'b001, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0));
        tbl.push_back(mk(3'b111, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b0, 3'b010, 1'b1, 9'h100, 1'b0, 9'h000, 2'd1));
        tbl.push_back(mk(3'b111, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b0, 3'b100, 1'b1, 9'h111, 1'b1, 9'h100, 2'd2));
        tbl.push_back(mk(3'b111, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b0, 3'b001, 1'b1, 9'h122, 1'b1, 9'h111, 2'd2));
        // Writeback stall for three cycles with all ports requesting.
        tbl.push_back(mk(3'b111, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b1, 3'b000, 1'b1, 9'h100, 1'b1, 9'h122, 2'd2));
        tbl.push_back(mk(3'b111, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b1, 3'b000, 1'b1, 9'h100, 1'b0, 9'h000, 2'd1));
        tbl.push_back(mk(3'b111, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b1, 3'b000, 1'b1, 9'h100, 1'b0, 9'h000, 2'd1));
        tbl.push_back(mk(3'b000, 3'b000, OP5, OP5, OP7, 9'h100, 9'h111, 9'h122, 1'b0, 3'b000, 1'b1, 9'h100, 1'b0, 9'h000, 2'd1));
        tbl.push_back(mk(3'b000, 3'b000, OP5, OP5, OP7, 9'h000, 9'h000, 9'h000, 1'b0, 3'b000, 1'b0, 9'h000, 1'b1, 9'h100, 2'd1));
        // Single request on port 1, tag 0x1A3 (row 9).
        tbl.push_back(mk(3'b010, 3'b000, OP5, OP5, OP5, 9'h000, 9'h1A3, 9'h000, 1'b0, 3'b010, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0));
        tbl.push_back(mk(3'b000, 3'b000, OP5, OP5, OP5, 9'h000, 9'h000, 9'h000, 1'b0, 3'b000, 1'b1, 9'h1A3, 1'b0, 9'h000, 2'd1));
        tbl.push_back(mk(3'b000, 3'b000, OP5, OP5, OP5, 9'h000, 9'h000, 9'h000, 1'b0, 3'b000, 1'b0, 9'h000, 1'b1, 9'h1A3, 2'd1));
        tbl.push_back(mk(3'b000, 3'b000, OP5, OP5, OP5, 9'h000, 9'h000, 9'h000, 1'b0, 3'b000, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0));
        // Opcode filter: port 0 has bit 11 set, port 1 is opcode 6.
        tbl.push_back(mk(3'b011, 3'b000, OPX11, OP6, OP5, 9'h000, 9'h055, 9'h000, 1'b0, 3'b010, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0));
        tbl.push_back(mk(3'b011, 3'b000, OPX11, OP6, OP5, 9'h000, 9'h055, 9'h000, 1'b0, 3'b010, 1'b1, 9'h055, 1'b0, 9'h000, 2'd1));
        tbl.push_back(mk(3'b001, 3'b000, OPX11, OP6, OP5, 9'h000, 9'h055, 9'h000, 1'b0, 3'b000, 1'b1, 9'h055, 1'b1, 9'h055, 2'd2));
        // Opcodes 4 and 8 sit just outside the shift class.
        tbl.push_back(mk(3'b101, 3'b000, OPX11, OP6, OP4, 9'h000, 9'h055, 9'h000, 1'b0, 3'b000, 1'b0, 9'h000, 1'b1, 9'h055, 2'd1));
        tbl.push_back(mk(3'b101, 3'b000, OPX11, OP6, OP8, 9'h000, 9'h055, 9'h000, 1'b0, 3'b000, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0));

        // Reset state, with requests already pending.
        rst = 1'b0;
        drive(3'b111, 3'b000, OP5, OP5, OP5, 9'h001, 9'h002, 9'h003, 1'b0, 1'b0, 1'b0);
        step();
        step();
        #1;
        check_all_zero("reset");
        idle();
        rst = 1'b1;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].valid, tbl[i].thread, tbl[i].op0, tbl[i].op1, tbl[i].op2,
                  tbl[i].tag0, tbl[i].tag1, tbl[i].tag2, tbl[i].stall, 1'b0, 1'b0);
            #2;
            check_out($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_rv, tbl[i].e_rtag,
                      tbl[i].e_fv, tbl[i].e_ftag, tbl[i].e_inf);
            if (i == 10) begin
                chk("vec10 sh_sel", 32'(sh_sel), 32'd1);
                chk("vec10 sh_operation", 32'(sh_operation), 32'(OP5));
            end
            step();
        end

        // Flush: S1 holds a thread-1 op, S2 a thread-0 op; port 0 (thread 1)
        // has round-robin priority but is filtered, port 2 (thread 0) wins.
        drive(3'b010, 3'b000, OP5, OP5, OP5, 9'h000, 9'h0A1, 9'h000, 1'b0, 1'b0, 1'b0);
        #2; check_out("flush_f0", 3'b010, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0); step();
        drive(3'b100, 3'b100, OP5, OP5, OP5, 9'h000, 9'h000, 9'h0B2, 1'b0, 1'b0, 1'b0);
        #2; check_out("flush_f1", 3'b100, 1'b1, 9'h0A1, 1'b0, 9'h000, 2'd1); step();
        drive(3'b101, 3'b001, OP5, OP5, OP5, 9'h0C0, 9'h000, 9'h0C2, 1'b0, 1'b1, 1'b1);
        #2; check_out("flush_f2", 3'b100, 1'b1, 9'h0B2, 1'b1, 9'h0A1, 2'd2);
        chk("flush_f2 res_thread", 32'(res_thread), 32'd1);
        step();
        idle();
        #2; check_out("flush_f3", 3'b000, 1'b1, 9'h0C2, 1'b0, 9'h000, 2'd1);
        chk("flush_f3 res_thread", 32'(res_thread), 32'd0);
        chk("flush_f3 sh_sel", 32'(sh_sel), 32'd2);
        step();
        #2; check_out("flush_f4", 3'b000, 1'b0, 9'h000, 1'b1, 9'h0C2, 2'd1); step();

        // Flush of a thread-1 op sitting in S2 suppresses its flags.
        drive(3'b001, 3'b001, OP5, OP5, OP5, 9'h0D0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0);
        #2; check_out("flush_f5", 3'b001, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0); step();
        idle();
        #2; check_out("flush_f6", 3'b000, 1'b1, 9'h0D0, 1'b0, 9'h000, 2'd1);
        chk("flush_f6 res_thread", 32'(res_thread), 32'd1);
        step();
        drive(3'b000, 3'b000, OP5, OP5, OP5, 9'h000, 9'h000, 9'h000, 1'b0, 1'b1, 1'b1);
        #2; check_out("flush_f7", 3'b000, 1'b0, 9'h000, 1'b0, 9'h000, 2'd1); step();

        // Flush wins over a stall: the stalled thread-1 op is dropped.
        drive(3'b001, 3'b001, OP5, OP5, OP5, 9'h0E0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0);
        #2; check_out("flush_f8", 3'b001, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0); step();
        drive(3'b010, 3'b000, OP5, OP5, OP5, 9'h000, 9'h0E1, 9'h000, 1'b1, 1'b1, 1'b1);
        #2; check_out("flush_f9", 3'b000, 1'b1, 9'h0E0, 1'b0, 9'h000, 2'd1); step();
        drive(3'b010, 3'b000, OP5, OP5, OP5, 9'h000, 9'h0E1, 9'h000, 1'b0, 1'b0, 1'b0);
        #2; check_out("flush_f10", 3'b010, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0); step();
        idle();
        #2; check_out("flush_f11", 3'b000, 1'b1, 9'h0E1, 1'b0, 9'h000, 2'd1); step();
        #2; check_out("flush_f12", 3'b000, 1'b0, 9'h000, 1'b1, 9'h0E1, 2'd1); step();

        // Reset mid-operation with inflight=2 and rr_ptr moved to port 2.
        drive(3'b001, 3'b000, OP5, OP5, OP5, 9'h0F0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0);
        #2; check_out("rst_a", 3'b001, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0); step();
        drive(3'b010, 3'b000, OP5, OP5, OP5, 9'h000, 9'h0F1, 9'h000, 1'b0, 1'b0, 1'b0);
        #2; check_out("rst_b", 3'b010, 1'b1, 9'h0F0, 1'b0, 9'h000, 2'd1); step();
        drive(3'b111, 3'b000, OP5, OP5, OP5, 9'h011, 9'h022, 9'h033, 1'b0, 1'b0, 1'b0);
        #2; check_out("rst_c", 3'b100, 1'b1, 9'h0F1, 1'b1, 9'h0F0, 2'd2);
        rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_release gnt", 32'(req_gnt), 32'b001);
        chk("rst_release inflight", 32'(inflight), 32'd0);
        step();
        idle();
        #2; check_out("rst_after1", 3'b000, 1'b1, 9'h011, 1'b0, 9'h000, 2'd1); step();
        #2; check_out("rst_after2", 3'b000, 1'b0, 9'h000, 1'b1, 9'h011, 2'd1); step();
        #2; check_out("rst_after3", 3'b000, 1'b0, 9'h000, 1'b0, 9'h000, 2'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
